// File: rtl/rv32i_inst_wb_pkg.sv
// Shared types and constants for the RV32I instruction-fetch Wishbone bridge.
package rv32i_inst_wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'hFFFF;

  localparam int RSP_ADDR_W = 32;
  localparam int RSP_DATA_W = 32;

  typedef struct packed {
    logic [RSP_DATA_W-1:0] data;
    logic [RSP_ADDR_W-1:0] addr;
    logic                  err;
  } rsp_t;

endpackage

// File: rtl/rv32i_inst_wb_sync_fifo.sv
// First-word fall-through synchronous FIFO with a same-cycle clear; the head
// entry is read straight from the storage registers.
module rv32i_inst_wb_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [31:0]      count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  // Storage is rounded up to a power of two; the extra pointer bit keeps
  // occupancy unambiguous, and capacity is still limited to DEPTH.
  logic [WIDTH-1:0] mem [2**AW];
  logic [AW:0]      wptr, rptr, used;
  logic             do_push, do_pop;

  assign used    = wptr - rptr;
  assign count   = 32'(used);
  assign empty   = (used == '0);
  assign full    = (32'(used) == DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rv32i_inst_wb_pipe_adapter.sv
// Fetch request/response to Wishbone B4 pipelined read bridge with flush and
// error reporting. Optional bus timeout: define RV32I_INST_WB_TIMEOUT_EN.
module rv32i_inst_wb_pipe_adapter
  import rv32i_inst_wb_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RSP_DEPTH       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic                flush_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_data_o,
  output logic [ADDR_W-1:0]   rsp_addr_o,
  output logic                rsp_err_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  input  logic                wb_stall_i,
  input  logic                wb_ack_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_err_i
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1) + 1;
  localparam int RSP_W = DATA_W + ADDR_W + 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   out_q, out_d, drop_q, drop_d;
  logic               stb_p1;
  logic [ADDR_W-1:0]  adr_p1;
  logic               accept, issue, term, drop_hit, done_hit, tmo_hit;
  logic [31:0]        in_flight, rsp_count, addr_count;
  logic               rsp_push, rsp_pop, rsp_empty, rsp_full;
  logic [RSP_W-1:0]   rsp_wdata, rsp_rdata;
  logic [ADDR_W-1:0]  head_addr;
  logic               addr_pop, addr_empty, addr_full;
  logic               unused_addr_fifo;

  assign term     = wb_ack_i || wb_err_i;
  assign issue    = stb_p1 && !wb_stall_i;
  assign drop_hit = term && (drop_q != '0);
  assign done_hit = term && !drop_hit && (out_q != '0);

  // A beat sitting in the issue stage already owns a bus slot and a response
  // slot, so it is counted alongside the issued-but-unacknowledged reads.
  assign in_flight   = 32'(out_q) + 32'(stb_p1);
  assign req_ready_o = !rst && (state_q != DRAIN) && !(stb_p1 && wb_stall_i) &&
                       (in_flight < 32'(MAX_OUTSTANDING)) &&
                       ((in_flight + rsp_count) < 32'(RSP_DEPTH)) && !flush_i;
  assign accept      = req_valid_i && req_ready_o;

`ifdef RV32I_INST_WB_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TIMEOUT_LIMIT) && (out_q != '0) && !term && !flush_i;

  always_ff @(posedge clk) begin
    if (rst) tmo_cnt <= '0;
    else if (term || flush_i || tmo_hit || (out_q == '0)) tmo_cnt <= '0;
    else tmo_cnt <= tmo_cnt + 16'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // A timed-out read retires as an error; its late ack is absorbed via drop_q.
  assign addr_pop  = done_hit || tmo_hit;
  assign rsp_push  = (done_hit || tmo_hit) && !flush_i;
  assign rsp_pop   = rsp_ready_i && !rsp_empty;
  assign rsp_wdata = tmo_hit ? {1'b1, head_addr, {DATA_W{1'b0}}}
                             : {wb_err_i, head_addr, (wb_err_i ? {DATA_W{1'b0}} : wb_dat_i)};

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    drop_d  = drop_q;
    if (flush_i) begin
      out_d   = '0;
      drop_d  = drop_q - CNT_W'(drop_hit) + out_q + CNT_W'(issue) - CNT_W'(done_hit);
      state_d = (drop_d != '0) ? DRAIN : IDLE;
    end else begin
      out_d  = out_q + CNT_W'(issue) - CNT_W'(done_hit) - CNT_W'(tmo_hit);
      drop_d = drop_q - CNT_W'(drop_hit) + CNT_W'(tmo_hit);
      unique case (state_q)
        IDLE:    if (accept) state_d = BUSY;
        BUSY:    if ((out_q == '0) && !stb_p1 && !accept && (drop_q == '0)) state_d = IDLE;
        DRAIN:   if (drop_d == '0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      drop_q  <= '0;
      stb_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      if (flush_i)     stb_p1 <= 1'b0;
      else if (accept) stb_p1 <= 1'b1;
      else if (issue)  stb_p1 <= 1'b0;
    end
  end

  // Issue stage p1: address register feeding the bus
  always_ff @(posedge clk) begin
    if (accept) adr_p1 <= req_addr_i;
  end

  rv32i_inst_wb_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTSTANDING)) u_addr_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush_i),
    .push  (issue),
    .wdata (adr_p1),
    .pop   (addr_pop),
    .rdata (head_addr),
    .empty (addr_empty),
    .full  (addr_full),
    .count (addr_count)
  );

  rv32i_inst_wb_sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush_i),
    .push  (rsp_push),
    .wdata (rsp_wdata),
    .pop   (rsp_pop),
    .rdata (rsp_rdata),
    .empty (rsp_empty),
    .full  (rsp_full),
    .count (rsp_count)
  );

  assign unused_addr_fifo = ^{addr_empty, addr_full, addr_count};

  assign rsp_valid_o = !rsp_empty;
  assign rsp_data_o  = rsp_rdata[DATA_W-1:0];
  assign rsp_addr_o  = rsp_rdata[DATA_W +: ADDR_W];
  assign rsp_err_o   = rsp_rdata[RSP_W-1];

  assign wb_cyc_o = (state_q != IDLE);
  assign wb_stb_o = stb_p1;
  assign wb_adr_o = adr_p1;
  assign wb_we_o  = 1'b0;
  assign wb_dat_o = '0;
  assign wb_sel_o = '1;

  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(rsp_push && rsp_full && !rsp_pop));

endmodule

// File: doc/rv32i_inst_wb_pipe_adapter.md
Name: rv32i_inst_wb_pipe_adapter

Overview:
- Second-generation instruction-fetch bridge: core-side request/response handshake to a Wishbone B4 pipelined master.
- Supports up to MAX_OUTSTANDING in-flight reads and a response FIFO.
- Adds flush on branch redirect and error reporting.
- Sits between the superscalar fetch unit and the instruction-memory Wishbone interconnect; one instance per fetch port.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- MAX_OUTSTANDING, 4, maximum issued-but-unacknowledged Wishbone reads; power of 2, at least 1.
- RSP_DEPTH, 4, response FIFO entries; must be at least MAX_OUTSTANDING.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  1  core fetch request valid
- req_ready_o  out  1  request accepted when valid and ready
- req_addr_i  in  ADDR_W  fetch byte address
- flush_i  in  1  discard all pending and in-flight fetches
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  core consumes response
- rsp_data_o  out  DATA_W  instruction data
- rsp_addr_o  out  ADDR_W  address of the returned data
- rsp_err_o  out  1  bus error for this response
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  tied 0
- wb_adr_o  out  ADDR_W  address
- wb_dat_o  out  DATA_W  tied 0
- wb_sel_o  out  DATA_W/8  all ones
- wb_stall_i  in  1  slave stall
- wb_ack_i  in  1  acknowledge
- wb_dat_i  in  DATA_W  read data
- wb_err_i  in  1  error termination

Behaviour:
- Reset (rst=1 at clk edge):
  - stb, cyc, rsp_valid_o all 0; req_ready_o 0 during the reset cycle.
  - Outstanding count, FIFO pointers and drop count cleared; FSM to IDLE.
  - Reset mid-transaction abandons the bus cycle; late acks after reset are ignored because the drop count is 0 and the outstanding count is 0.
- Issue path:
  - req_ready_o = !stall_hold && outstanding < MAX_OUTSTANDING && (outstanding + fifo_count) < RSP_DEPTH && !flush_i.
  - A request is accepted on req_valid_i && req_ready_o; wb_stb_o, wb_adr_o and the address copy drive from a registered issue stage.
  - stb rises one cycle after acceptance (latency 1).
  - While wb_stb_o && wb_stall_i: the issue stage holds its address, stall_hold=1, no new acceptance.
  - The beat is issued on stb && !stall; outstanding increments.
  - Back-to-back issue each cycle is allowed when not stalled.
- FSM:
  - IDLE: cyc=0. Go to BUSY on acceptance.
  - BUSY: cyc=1. Go to IDLE when outstanding==0, no stb pending and no acceptance this cycle.
  - DRAIN: entered on flush while outstanding>0. cyc stays 1, stb=0. Acks and errs are counted and discarded. Go to IDLE when the drop count reaches 0.
  - Requests are not accepted in DRAIN.
- Termination:
  - ack or err decrements outstanding (simultaneous issue and ack nets to 0).
  - Outside DRAIN, the data, its address (from an address-tracking FIFO of depth MAX_OUTSTANDING) and err are pushed to the response FIFO; data forced to 0 on err.
  - ack and err asserted together count as err.
- Response FIFO:
  - rsp_valid_o = !empty; first-word fall-through, with outputs registered from the FIFO head.
  - Pop on rsp_valid_o && rsp_ready_i.
  - Push and pop in the same cycle when full are legal; occupancy is unchanged.
  - Pointers wrap modulo RSP_DEPTH; full/empty are tracked with an extra pointer bit.
- flush_i:
  - Same-cycle effect: the response FIFO and address FIFO are cleared.
  - Any unissued stb beat is dropped; stb=0 next cycle.
  - drop_count = outstanding minus any ack in that cycle.
  - rsp_valid_o is 0 the cycle after.
  - flush with a simultaneous req_valid_i: the request is not accepted.
- Overflow of the response FIFO is impossible by the ready rule; an assertion checks it.

Optional Feature:
- RV32I_INST_WB_TIMEOUT_EN defined:
  - A 16-bit counter runs while outstanding>0 and no ack/err arrives.
  - It reloads on any termination.
  - When it hits 0xFFFF: the oldest outstanding entry is retired as a response with rsp_err_o=1, outstanding decrements, and one late ack is added to the drop count.
- Not defined: no counter; a hung slave stalls forever.

Decomposition:
- Package rv32i_inst_wb_pkg: state typedef (IDLE, BUSY, DRAIN), timeout constant 16'hFFFF, and a response struct {data, addr, err}.
- Sub-module rv32i_inst_wb_sync_fifo, parametrised by width and depth with a clear input.
  - Instanced twice: address tracking and response.

Test Plan:
- Single fetch: req 0x0000_0100, slave ack after 2 cycles with 0x0000_0013 -> rsp_valid_o with data 0x13, addr 0x100, err 0; cyc drops once idle.
- Pipelined burst: 4 requests 0x0, 0x4, 0x8, 0xC with zero-wait slave -> 4 stb beats on consecutive cycles, responses in order; a 5th request is held off until the first ack.
- Stall: wb_stall_i high 3 cycles on beat 0x20 -> wb_adr_o stable at 0x20, req_ready_o 0, exactly one beat issued.
- Flush: 3 outstanding, flush_i pulse, then 3 late acks -> no rsp_valid_o, FSM in DRAIN until the 3rd ack, then accepts a new request at 0x200.
- Error: slave asserts wb_err_i on 0x40 -> rsp_err_o=1, data 0, addr 0x40; subsequent fetch at 0x44 succeeds normally.
- Backpressure and reset: rsp_ready_i=0 with the FIFO full -> req_ready_o 0; rst asserted mid-burst -> all outputs 0 next cycle, stray ack ignored.
